bus_datapath: RTL and testbench



---
 rtl/datapath_pkg.sv | 38 +++
 rtl/muldiv_seq.sv | 106 ++++++++++
 rtl/register_w.sv | 23 ++
 rtl/bus_datapath.sv | 171 +++++++++++++++++
 tb/tb_bus_datapath.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// Shared encodings for the single-bus datapath: ALU opcodes, bus-source
// offsets above the general registers, and the MUL/DIV sequencer states.
package datapath_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SHR  = 4'd4,
    OP_SHRA = 4'd5,
    OP_SHL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_ROL  = 4'd8,
    OP_NEG  = 4'd9,
    OP_NOT  = 4'd10,
    OP_MUL  = 4'd11,
    OP_DIV  = 4'd12
  } alu_op_t;

  // Bus-source indices are NREGS + offset; lower index wins arbitration.
  localparam int SRC_HI        = 0;
  localparam int SRC_LO        = 1;
  localparam int SRC_ZHI       = 2;
  localparam int SRC_ZLO       = 3;
  localparam int SRC_PC        = 4;
  localparam int SRC_MDR       = 5;
  localparam int SRC_INPORT    = 6;
  localparam int SRC_C         = 7;
  localparam int N_SPECIAL_SRC = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative signed multiply/divide: magnitudes are processed one bit per
// RUN cycle (shift-add or restoring subtract); signs are applied in DONE.
module muldiv_seq
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               i_start,
  input  logic               i_is_div,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_result
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  seq_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div, r_a_sign, r_b_sign, r_div_zero;
  logic [WIDTH-1:0]   r_dividend, r_b_mag;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_accept;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_mul_sum, w_div_diff;
  logic [2*WIDTH-1:0] w_mul_next, w_div_sh, w_div_next;

  // A new operation may also be accepted in the DONE cycle, back to back.
  assign w_accept = i_start && (r_state != S_RUN);
  assign w_a_mag  = i_a[WIDTH-1] ? -i_a : i_a;
  assign w_b_mag  = i_b[WIDTH-1] ? -i_b : i_b;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: assigning a default before the case keeps every path driven, so
  // no latch is inferred for the next-state signal.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = w_accept ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Multiply: upper half accumulates, low half holds the shrinking multiplier.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      {1'b0, (r_acc[0] ? r_b_mag : {WIDTH{1'b0}})};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: {remainder, quotient} shifts left; quotient bits enter at bit 0.
  assign w_div_sh   = {r_acc[2*WIDTH-2:0], 1'b0};
  assign w_div_diff = {1'b0, w_div_sh[2*WIDTH-1:WIDTH]} - {1'b0, r_b_mag};
  assign w_div_next = w_div_diff[WIDTH] ? w_div_sh
                                        : {w_div_diff[WIDTH-1:0], w_div_sh[WIDTH-1:1], 1'b1};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_a_sign   <= 1'b0;
      r_b_sign   <= 1'b0;
      r_div_zero <= 1'b0;
      r_dividend <= '0;
      r_b_mag    <= '0;
      r_acc      <= '0;
    end else if (w_accept) begin
      r_cnt      <= '0;
      r_is_div   <= i_is_div;
      r_a_sign   <= i_a[WIDTH-1];
      r_b_sign   <= i_b[WIDTH-1];
      r_div_zero <= (i_b == '0);
      r_dividend <= i_a;
      r_b_mag    <= w_b_mag;
      r_acc      <= {{WIDTH{1'b0}}, w_a_mag};
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= r_is_div ? w_div_next : w_mul_next;
    end
  end

  always_comb begin
    o_result = r_acc;
    if (!r_is_div) begin
      if (r_a_sign ^ r_b_sign) o_result = -r_acc;
    end else if (r_div_zero) begin
      o_result = {r_dividend, {WIDTH{1'b1}}};
    end else begin
      o_result[WIDTH-1:0]       = (r_a_sign ^ r_b_sign) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      o_result[2*WIDTH-1:WIDTH] = r_a_sign ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = (r_state == S_DONE);

endmodule

// File: rtl/register_w.sv
// Load-enabled register cell with asynchronous active-high clear.
module register_w #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // NOTE: sequential state is written with <= so every register samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)       r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/bus_datapath.sv
// Single-bus CPU datapath with priority bus mux and ALU. Define
// DATAPATH_MULDIV_EN to build the iterative signed MUL/DIV sequencer.
module bus_datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int C_W   = 19
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [NREGS-1:0] reg_in,
  input  logic [NREGS-1:0] reg_out,
  input  logic             pc_in,
  input  logic             ir_in,
  input  logic             y_in,
  input  logic             z_in,
  input  logic             hi_in,
  input  logic             lo_in,
  input  logic             mar_in,
  input  logic             mdr_in,
  input  logic             outport_in,
  input  logic             hi_out,
  input  logic             lo_out,
  input  logic             zhi_out,
  input  logic             zlo_out,
  input  logic             pc_out,
  input  logic             mdr_out,
  input  logic             inport_out,
  input  logic             c_out,
  input  logic             read,
  input  logic [3:0]       alu_op,
  input  logic             alu_start,
  input  logic [WIDTH-1:0] mem_data_in,
  input  logic [WIDTH-1:0] inport_data,
  output logic [WIDTH-1:0] bus_q,
  output logic [WIDTH-1:0] mar_q,
  output logic [WIDTH-1:0] mdr_q,
  output logic [WIDTH-1:0] outport_q,
  output logic             bus_conflict,
  output logic             alu_busy,
  output logic             alu_done
);

  localparam int NSRC = NREGS + N_SPECIAL_SRC;
  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   w_bus, w_c, w_mdr_d;
  logic [WIDTH-1:0]   w_gpr [NREGS];
  logic [WIDTH-1:0]   w_pc, w_ir, w_y, w_hi, w_lo, w_mdr, w_inport;
  logic [2*WIDTH-1:0] r_z;
  logic [WIDTH-1:0]   w_src [NSRC];
  logic [NSRC-1:0]    w_src_en;
  logic               w_seq_busy, w_seq_done;
  logic [2*WIDTH-1:0] w_seq_result, w_alu_result;
  logic [WIDTH-1:0]   w_alu_lo;
  logic [WIDTH:0]     w_sum, w_diff;
  logic [2*WIDTH-1:0] w_rot_r, w_rot_l;
  logic [SH_W-1:0]    w_shamt;
  logic               w_unused;

  for (genvar g = 0; g < NREGS; g++) begin : g_gpr
    register_w #(.WIDTH(WIDTH)) u_reg (
      .clk(clk), .clr(clr), .i_en(reg_in[g]), .i_d(w_bus), .o_q(w_gpr[g])
    );
  end

  assign w_mdr_d = read ? mem_data_in : w_bus;

  register_w #(.WIDTH(WIDTH)) u_pc  (.clk(clk), .clr(clr), .i_en(pc_in),  .i_d(w_bus), .o_q(w_pc));
  register_w #(.WIDTH(WIDTH)) u_ir  (.clk(clk), .clr(clr), .i_en(ir_in),  .i_d(w_bus), .o_q(w_ir));
  register_w #(.WIDTH(WIDTH)) u_y   (.clk(clk), .clr(clr), .i_en(y_in),   .i_d(w_bus), .o_q(w_y));
  register_w #(.WIDTH(WIDTH)) u_hi  (.clk(clk), .clr(clr), .i_en(hi_in),  .i_d(w_bus), .o_q(w_hi));
  register_w #(.WIDTH(WIDTH)) u_lo  (.clk(clk), .clr(clr), .i_en(lo_in),  .i_d(w_bus), .o_q(w_lo));
  register_w #(.WIDTH(WIDTH)) u_mar (.clk(clk), .clr(clr), .i_en(mar_in), .i_d(w_bus), .o_q(mar_q));
  register_w #(.WIDTH(WIDTH)) u_mdr (.clk(clk), .clr(clr), .i_en(mdr_in), .i_d(w_mdr_d), .o_q(w_mdr));
  register_w #(.WIDTH(WIDTH)) u_out (.clk(clk), .clr(clr), .i_en(outport_in), .i_d(w_bus), .o_q(outport_q));
  register_w #(.WIDTH(WIDTH)) u_in  (.clk(clk), .clr(clr), .i_en(1'b1), .i_d(inport_data), .o_q(w_inport));

  assign mdr_q = w_mdr;
  assign w_c   = WIDTH'($signed(w_ir[C_W-1:0]));

  always_comb begin
    for (int i = 0; i < NREGS; i++) w_src[i] = w_gpr[i];
    w_src[NREGS+SRC_HI]     = w_hi;
    w_src[NREGS+SRC_LO]     = w_lo;
    w_src[NREGS+SRC_ZHI]    = r_z[2*WIDTH-1:WIDTH];
    w_src[NREGS+SRC_ZLO]    = r_z[WIDTH-1:0];
    w_src[NREGS+SRC_PC]     = w_pc;
    w_src[NREGS+SRC_MDR]    = w_mdr;
    w_src[NREGS+SRC_INPORT] = w_inport;
    w_src[NREGS+SRC_C]      = w_c;
  end

  assign w_src_en = {c_out, inport_out, mdr_out, pc_out, zlo_out, zhi_out, lo_out, hi_out, reg_out};

  // Scan from the top down so the lowest-index enabled source is written last.
  always_comb begin
    w_bus = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_src_en[i]) w_bus = w_src[i];
    end
  end

  assign bus_q        = w_bus;
  assign bus_conflict = |(w_src_en & (w_src_en - NSRC'(1)));

  assign w_shamt = w_bus[SH_W-1:0];
  assign w_sum   = {1'b0, w_y} + {1'b0, w_bus};
  assign w_diff  = {1'b0, w_y} - {1'b0, w_bus};
  assign w_rot_r = {w_y, w_y} >> w_shamt;
  assign w_rot_l = {w_y, w_y} << w_shamt;

  always_comb begin
    w_alu_lo = '0;
    case (alu_op_t'(alu_op))
      OP_AND:  w_alu_lo = w_y & w_bus;
      OP_OR:   w_alu_lo = w_y | w_bus;
      OP_SHR:  w_alu_lo = w_y >> w_shamt;
      OP_SHRA: w_alu_lo = $signed(w_y) >>> w_shamt;
      OP_SHL:  w_alu_lo = w_y << w_shamt;
      OP_ROR:  w_alu_lo = w_rot_r[WIDTH-1:0];
      OP_ROL:  w_alu_lo = w_rot_l[2*WIDTH-1:WIDTH];
      OP_NEG:  w_alu_lo = -w_bus;
      OP_NOT:  w_alu_lo = ~w_bus;
      default: w_alu_lo = '0;
    endcase
  end

  always_comb begin
    case (alu_op_t'(alu_op))
      OP_ADD:  w_alu_result = {{(WIDTH-1){1'b0}}, w_sum};
      OP_SUB:  w_alu_result = {{(WIDTH-1){1'b0}}, w_diff};
      default: w_alu_result = {{WIDTH{1'b0}}, w_alu_lo};
    endcase
  end

`ifdef DATAPATH_MULDIV_EN
  logic w_seq_start;
  assign w_seq_start = alu_start &&
                       (alu_op == OP_MUL || alu_op == OP_DIV);

  muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .clr      (clr),
    .i_start  (w_seq_start),
    .i_is_div (alu_op == OP_DIV),
    .i_a      (w_y),
    .i_b      (w_bus),
    .o_busy   (w_seq_busy),
    .o_done   (w_seq_done),
    .o_result (w_seq_result)
  );
`else
  assign w_seq_busy   = 1'b0;
  assign w_seq_done   = 1'b0;
  assign w_seq_result = '0;
`endif

  // While the sequencer is active it alone owns Z.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                      r_z <= '0;
    else if (w_seq_done)          r_z <= w_seq_result;
    else if (z_in && !w_seq_busy) r_z <= w_alu_result;
  end

  assign alu_busy = w_seq_busy;
  assign alu_done = w_seq_done;
  assign w_unused = ^{w_ir, alu_start};

endmodule

// File: tb/tb_bus_datapath.sv
// Directed bench for bus_datapath: bus arbitration, register transfers, ALU ops
// and, when DATAPATH_MULDIV_EN is defined, the MUL/DIV sequencer.
module tb_bus_datapath;

  localparam int W  = 32;
  localparam int N  = 16;
  localparam int CW = 19;

  logic         clk = 1'b0;
  logic         clr;
  logic [N-1:0] reg_in, reg_out;
  logic         pc_in, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in, outport_in;
  logic         hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out;
  logic         read, alu_start;
  logic [3:0]   alu_op;
  logic [W-1:0] mem_data_in, inport_data;
  logic [W-1:0] bus_q, mar_q, mdr_q, outport_q;
  logic         bus_conflict, alu_busy, alu_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bus_datapath #(.WIDTH(W), .NREGS(N), .C_W(CW)) dut (
    .clk(clk), .clr(clr), .reg_in(reg_in), .reg_out(reg_out),
    .pc_in(pc_in), .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
    .mar_in(mar_in), .mdr_in(mdr_in), .outport_in(outport_in),
    .hi_out(hi_out), .lo_out(lo_out), .zhi_out(zhi_out), .zlo_out(zlo_out),
    .pc_out(pc_out), .mdr_out(mdr_out), .inport_out(inport_out), .c_out(c_out),
    .read(read), .alu_op(alu_op), .alu_start(alu_start),
    .mem_data_in(mem_data_in), .inport_data(inport_data),
    .bus_q(bus_q), .mar_q(mar_q), .mdr_q(mdr_q), .outport_q(outport_q),
    .bus_conflict(bus_conflict), .alu_busy(alu_busy), .alu_done(alu_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reg_in = '0; reg_out = '0;
    {pc_in, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in, outport_in} = '0;
    {hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out} = '0;
    read = 1'b0; alu_start = 1'b0; alu_op = 4'd0;
  endtask

  task automatic load_mdr(input logic [W-1:0] v);
    read = 1'b1; mdr_in = 1'b1; mem_data_in = v;
    tick();
    read = 1'b0; mdr_in = 1'b0;
  endtask

  task automatic set_reg(input int idx, input logic [W-1:0] v);
    load_mdr(v);
    mdr_out = 1'b1; reg_in[idx] = 1'b1;
    tick();
    mdr_out = 1'b0; reg_in = '0;
  endtask

  task automatic set_y_from(input int idx);
    reg_out[idx] = 1'b1; y_in = 1'b1;
    tick();
    reg_out = '0; y_in = 1'b0;
  endtask

  task automatic read_z(output logic [63:0] z);
    zhi_out = 1'b1; #1; z[63:32] = bus_q; zhi_out = 1'b0;
    zlo_out = 1'b1; #1; z[31:0]  = bus_q; zlo_out = 1'b0;
    #1;
  endtask

  // Single-cycle op with A = Y, B = R[b_idx]; result read back from Z.
  task automatic alu_single(input logic [3:0] op, input int b_idx, output logic [63:0] z);
    alu_op = op; reg_out[b_idx] = 1'b1; z_in = 1'b1;
    tick();
    reg_out = '0; z_in = 1'b0;
    read_z(z);
  endtask

  // Starts MUL/DIV with B from R[b_idx] (b_idx < 0: empty bus) and returns the
  // number of edges after the start edge until alu_done is observed.
  task automatic run_muldiv(input logic [3:0] op, input int b_idx, output int lat);
    alu_op = op; alu_start = 1'b1;
    if (b_idx >= 0) reg_out[b_idx] = 1'b1;
    tick();
    alu_start = 1'b0; reg_out = '0;
    check("busy_after_start", {63'd0, alu_busy}, 64'd1);
    lat = 0;
    while (!alu_done && lat < 40) begin
      tick();
      lat++;
    end
    tick();
  endtask

  logic [63:0] z;
  logic [3:0]  op_tbl  [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd10, 4'd13};
  logic [31:0] exp_tbl [8] = '{32'h0000_000C, 32'h0000_0002, 32'h0000_0005, 32'h0000_0007,
                               32'h0000_00E0, 32'h3800_0000, 32'hFFFF_FFFA, 32'h0000_0000};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  lat;
    logic done_seen;
    idle_inputs();
    mem_data_in = '0; inport_data = '0;
    clr = 1'b1;
    #12;
    check("rst_bus", {32'd0, bus_q}, 64'd0);
    check("rst_mar", {32'd0, mar_q}, 64'd0);
    check("rst_mdr", {32'd0, mdr_q}, 64'd0);
    check("rst_outport", {32'd0, outport_q}, 64'd0);
    check("rst_busy_done", {62'd0, alu_busy, alu_done}, 64'd0);
    read_z(z);
    check("rst_z", z, 64'd0);
    @(negedge clk);
    clr = 1'b0;
    tick();

    set_reg(3, 32'h0000_0007);
    set_reg(5, 32'h0000_0005);
    set_reg(6, 32'hFFFF_FFFF);
    set_reg(7, 32'h0000_0001);
    reg_out[3] = 1'b1; #1;
    check("r3_on_bus", {32'd0, bus_q}, 64'h7);
    reg_out = '0;

    set_y_from(3);
    for (int i = 0; i < 8; i++) begin
      alu_single(op_tbl[i], 5, z);
      check($sformatf("alu_op%0d_7_5", op_tbl[i]), z, {32'd0, exp_tbl[i]});
    end

    set_y_from(5);
    alu_single(4'd1, 3, z);
    check("sub_borrow", z, 64'h0000_0001_FFFF_FFFE);
    set_y_from(6);
    alu_single(4'd0, 7, z);
    check("add_carry", z, 64'h0000_0001_0000_0000);
    alu_single(4'd5, 5, z);
    check("shra_neg", z, 64'h0000_0000_FFFF_FFFF);
    alu_single(4'd4, 5, z);
    check("shr_neg", z, 64'h0000_0000_07FF_FFFF);
    alu_single(4'd8, 7, z);
    check("rol_neg", z, 64'h0000_0000_FFFF_FFFF);

    set_reg(2, 32'h0000_1234);
    load_mdr(32'h0000_BEEF);
    mdr_out = 1'b1; pc_in = 1'b1; tick(); mdr_out = 1'b0; pc_in = 1'b0;
    load_mdr(32'h0000_CAFE);
    reg_out[2] = 1'b1; pc_out = 1'b1; #1;
    check("conf_r2_pc_bus", {32'd0, bus_q}, 64'h1234);
    check("conf_r2_pc_flag", {63'd0, bus_conflict}, 64'd1);
    reg_out = '0; #1;
    check("pc_only_flag", {63'd0, bus_conflict}, 64'd0);
    mdr_out = 1'b1; #1;
    check("conf_pc_mdr_bus", {32'd0, bus_q}, 64'hBEEF);
    pc_out = 1'b0; mdr_out = 1'b0; #1;
    check("no_src_bus", {32'd0, bus_q}, 64'd0);
    check("no_src_flag", {63'd0, bus_conflict}, 64'd0);

    load_mdr(32'h0004_0000);
    mdr_out = 1'b1; ir_in = 1'b1; tick(); mdr_out = 1'b0; ir_in = 1'b0;
    c_out = 1'b1; #1;
    check("c_sign_ext", {32'd0, bus_q}, 64'hFFFC_0000);
    c_out = 1'b0;

    load_mdr(32'hA5A5_A5A5);
    check("mdr_read", {32'd0, mdr_q}, 64'hA5A5_A5A5);
    mem_data_in = 32'h1111_1111;
    mdr_out = 1'b1; mar_in = 1'b1; outport_in = 1'b1; tick();
    mdr_out = 1'b0; mar_in = 1'b0; outport_in = 1'b0;
    check("mdr_hold", {32'd0, mdr_q}, 64'hA5A5_A5A5);
    check("mar_load", {32'd0, mar_q}, 64'hA5A5_A5A5);
    check("outport_load", {32'd0, outport_q}, 64'hA5A5_A5A5);
    inport_data = 32'h0000_005A; tick();
    inport_out = 1'b1; #1;
    check("inport_bus", {32'd0, bus_q}, 64'h5A);
    inport_out = 1'b0;

`ifdef DATAPATH_MULDIV_EN
    set_reg(8, 32'hFFFF_FFFD);
    set_y_from(8);
    alu_op = 4'd11; alu_start = 1'b1; reg_out[3] = 1'b1;
    tick();
    alu_start = 1'b0; reg_out = '0;
    alu_op = 4'd0; z_in = 1'b1;
    check("mul_busy", {63'd0, alu_busy}, 64'd1);
    lat = 0;
    while (!alu_done && lat < 40) begin
      tick();
      lat++;
    end
    check("mul_latency", lat, 64'd32);
    tick();
    z_in = 1'b0;
    check("mul_idle_after", {62'd0, alu_busy, alu_done}, 64'd0);
    read_z(z);
    check("mul_neg3_x7", z, 64'hFFFF_FFFF_FFFF_FFEB);

    set_reg(9, 32'hFFFF_FFF9);
    set_reg(10, 32'h0000_0002);
    set_y_from(9);
    run_muldiv(4'd12, 10, lat);
    check("div_latency", lat, 64'd32);
    read_z(z);
    check("div_neg7_2", z, 64'hFFFF_FFFF_FFFF_FFFD);

    set_reg(12, 32'hFFFF_FFFE);
    set_y_from(3);
    run_muldiv(4'd12, 12, lat);
    read_z(z);
    check("div_7_neg2", z, 64'h0000_0001_FFFF_FFFD);

    set_reg(11, 32'h0000_0009);
    set_y_from(11);
    run_muldiv(4'd12, -1, lat);
    read_z(z);
    check("div_by_zero", z, 64'h0000_0009_FFFF_FFFF);

    set_y_from(8);
    alu_op = 4'd11; alu_start = 1'b1; reg_out[3] = 1'b1;
    tick();
    alu_start = 1'b0; reg_out = '0;
    repeat (4) tick();
    clr = 1'b1; #1;
    check("clr_mid_run_busy", {63'd0, alu_busy}, 64'd0);
    clr = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (alu_done) done_seen = 1'b1;
    end
    check("clr_mid_run_no_done", {63'd0, done_seen}, 64'd0);
    read_z(z);
    check("clr_mid_run_z", z, 64'd0);
`else
    set_y_from(3);
    alu_single(4'd0, 5, z);
    check("pre_mul_add", z, 64'h0000_0000_0000_000C);
    alu_op = 4'd11; alu_start = 1'b1; z_in = 1'b1; reg_out[5] = 1'b1;
    tick();
    alu_start = 1'b0; z_in = 1'b0; reg_out = '0;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (alu_busy || alu_done) done_seen = 1'b1;
      tick();
    end
    check("no_seq_busy_done", {63'd0, done_seen}, 64'd0);
    read_z(z);
    check("no_seq_mul_zero", z, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
